wf_axis_reader: RTL and testbench

- Drains the TX-bridge write FIFO pair: the byte-count FIFO (wcf) and the 64-bit data FIFO (wf).
- Re-emits each stored packet as an AXI4-Stream master frame on the DMA clock domain.
- Consumer/reader end of the rdempty/dataout/rden interface that the bridge exports for those FIFOs.
- Sits between the bridge's write FIFOs and the DMA/host AXIS ingress.

---
 rtl/wf_rd_pkg.sv | 52 +++++
 rtl/wf_rd_skid.sv | 58 +++++
 rtl/wf_axis_reader.sv | 175 +++++++++++++++++
 tb/tb_wf_axis_reader.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/wf_rd_pkg.sv
// ============================================================================
//  Module   : wf_rd_pkg
//  Purpose  : Shared types, constants and helpers for the TX-bridge write-FIFO
//             reader (FSM states, skid beat record, keep-mask helpers).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package wf_rd_pkg;

  // Reader control states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEN   = 2'd1,
    ST_DATA  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Cycles from rden to valid dataout on a normal-mode FIFO
  localparam int FIFO_RD_LAT = 1;

  // Bytes carried by one 64-bit data word
  localparam int QW_BYTES = 8;

  // One stream beat as held in the skid buffer
  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  // Lane mask for the final word: a zero remainder means a full word
  function automatic logic [7:0] keep_from_cnt(input logic [2:0] rem);
    if (rem == 3'd0) begin
      return 8'hFF;
    end
    return 8'hFF >> (4'd8 - {1'b0, rem});
  endfunction

  // Number of valid byte lanes in a keep mask
  function automatic logic [3:0] keep_bytes(input logic [7:0] keep);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, keep[i]};
    end
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wf_rd_skid.sv
// ============================================================================
//  Module   : wf_rd_skid
//  Purpose  : Two-entry registered beat buffer feeding the AXIS master port.
//             Entry 0 is the head; count reports occupancy for credit checks.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wf_rd_skid
  import wf_rd_pkg::*;
(
  input  logic       clk,
  input  logic       reset_,
  input  logic       push,
  input  beat_t      din,
  input  logic       pop,
  output beat_t      head,
  output logic [1:0] count
);

  beat_t ent1;

  // Shift-style two-entry queue; push and pop together keep the count
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      head  <= '0;
      ent1  <= '0;
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head <= din;
          end else begin
            ent1 <= din;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= ent1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd2) begin
            head <= ent1;
            ent1 <= din;
          end else begin
            head <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/wf_axis_reader.sv
// ============================================================================
//  Module   : wf_axis_reader
//  Purpose  : Drains the byte-count FIFO (wcf) and 64-bit data FIFO (wf) of
//             the TX bridge and re-emits each packet as an AXI4-Stream frame.
//  Options  : WF_RD_PKT_STATS_EN adds pkt_cnt / byte_cnt statistics outputs.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wf_axis_reader
  import wf_rd_pkg::*;
#(
  parameter int MAX_BYTES = 9600,
  parameter int CNT_W     = 16
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic        rdempty_wcf,
  input  logic [31:0] dataout_wcf,
  output logic        rden_wcf,
  input  logic        rdempty_wf,
  input  logic [63:0] dataout_wf,
  output logic        rden_wf,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [63:0] m_axis_tdata,
  output logic [7:0]  m_axis_tkeep,
  output logic        m_axis_tlast,
  output logic        err_zero_len,
  output logic        err_len,
`ifdef WF_RD_PKT_STATS_EN
  output logic [31:0] pkt_cnt,
  output logic [47:0] byte_cnt,
`endif
  output logic        busy
);

  localparam int QW_W = CNT_W - 2;

  state_t                 state;
  logic [QW_W-1:0]        qw_left;
  logic [QW_W-1:0]        issued;
  logic [7:0]             last_keep;
  logic [FIFO_RD_LAT-1:0] wcf_pipe;
  logic                   rden_last;
  logic                   rd_vld;
  logic                   rd_last;
  logic [1:0]             skid_count;
  beat_t                  skid_din;
  beat_t                  skid_head;
  logic                   skid_pop;
  logic                   out_valid;
  logic [CNT_W-1:0]       cnt_in;
  logic [CNT_W:0]         qw_calc;
  logic                   credit_ok;
  logic                   issue_ok;
  logic                   unused_bits;

  assign cnt_in  = dataout_wcf[CNT_W-1:0];
  assign qw_calc = ({1'b0, cnt_in} + (CNT_W+1)'(QW_BYTES - 1)) >> 3;
  assign unused_bits = &{1'b0, dataout_wcf[31:CNT_W], qw_calc[CNT_W:QW_W]};

  // Credit only looks at registered state: buffered words plus the word
  // returning this cycle. Issue never runs back-to-back so rdempty is fresh.
  assign credit_ok = ({1'b0, skid_count} + {2'b00, rd_vld}) < 3'd2;
  assign issue_ok  = (state == ST_DATA) && !rdempty_wf && !rden_wf &&
                     (issued < qw_left) && credit_ok;

  // Reader FSM: count pop, length decode, data issue and last-beat drain
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state        <= ST_IDLE;
      rden_wcf     <= 1'b0;
      rden_wf      <= 1'b0;
      rden_last    <= 1'b0;
      wcf_pipe     <= '0;
      rd_vld       <= 1'b0;
      rd_last      <= 1'b0;
      qw_left      <= '0;
      issued       <= '0;
      last_keep    <= 8'h00;
      err_zero_len <= 1'b0;
      err_len      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      rden_wcf     <= 1'b0;
      rden_wf      <= 1'b0;
      rden_last    <= 1'b0;
      err_zero_len <= 1'b0;
      err_len      <= 1'b0;
      wcf_pipe     <= (wcf_pipe << 1) | FIFO_RD_LAT'(rden_wcf);
      rd_vld       <= rden_wf;
      rd_last      <= rden_last;
      case (state)
        ST_IDLE: begin
          if (!rdempty_wcf) begin
            rden_wcf <= 1'b1;
            state    <= ST_LEN;
          end
        end
        ST_LEN: begin
          if (wcf_pipe[FIFO_RD_LAT-1]) begin
            qw_left   <= qw_calc[QW_W-1:0];
            last_keep <= keep_from_cnt(cnt_in[2:0]);
            issued    <= '0;
            if (cnt_in == '0) begin
              err_zero_len <= 1'b1;
              state        <= ST_IDLE;
            end else begin
              err_len <= (32'(cnt_in) > 32'(MAX_BYTES));
              busy    <= 1'b1;
              state   <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (issue_ok) begin
            rden_wf <= 1'b1;
            issued  <= issued + QW_W'(1);
            if ((issued + QW_W'(1)) == qw_left) begin
              rden_last <= 1'b1;
              state     <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (out_valid && m_axis_tready && skid_head.last) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign skid_din.data = dataout_wf;
  assign skid_din.keep = rd_last ? last_keep : 8'hFF;
  assign skid_din.last = rd_last;
  assign out_valid     = (skid_count != 2'd0);
  assign skid_pop      = out_valid && m_axis_tready;

  wf_rd_skid u_skid (
    .clk    (clk),
    .reset_ (reset_),
    .push   (rd_vld),
    .din    (skid_din),
    .pop    (skid_pop),
    .head   (skid_head),
    .count  (skid_count)
  );

  assign m_axis_tvalid = out_valid;
  assign m_axis_tdata  = skid_head.data;
  assign m_axis_tkeep  = skid_head.keep;
  assign m_axis_tlast  = skid_head.last;

`ifdef WF_RD_PKT_STATS_EN
  // Packet and byte statistics on accepted beats; both wrap silently
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      pkt_cnt  <= 32'd0;
      byte_cnt <= 48'd0;
    end else if (skid_pop) begin
      byte_cnt <= byte_cnt + 48'(keep_bytes(skid_head.keep));
      if (skid_head.last) begin
        pkt_cnt <= pkt_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_wf_axis_reader.sv
// ============================================================================
//  Module   : tb_wf_axis_reader
//  Purpose  : Scoreboard bench for wf_axis_reader with FIFO models on both
//             read ports and a decoupled AXIS monitor.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wf_axis_reader;

  logic        clk = 1'b0;
  logic        reset_ = 1'b0;
  logic        rdempty_wcf = 1'b1;
  logic [31:0] dataout_wcf = '0;
  logic        rden_wcf;
  logic        rdempty_wf = 1'b1;
  logic [63:0] dataout_wf = '0;
  logic        rden_wf;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic        err_zero_len;
  logic        err_len;
  logic        busy;

  wf_axis_reader dut (
    .clk           (clk),
    .reset_        (reset_),
    .rdempty_wcf   (rdempty_wcf),
    .dataout_wcf   (dataout_wcf),
    .rden_wcf      (rden_wcf),
    .rdempty_wf    (rdempty_wf),
    .dataout_wf    (dataout_wf),
    .rden_wf       (rden_wf),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .err_zero_len  (err_zero_len),
    .err_len       (err_len),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int ready_pct = 100;
  int wf_pops = 0;
  int beats_acc = 0;
  int zl_cnt = 0;
  int el_cnt = 0;
  int max_out = 0;

  logic [31:0] wcf_q[$];
  logic [63:0] wf_q[$];
  logic [72:0] sb_q[$];

  logic        stall_prev = 1'b0;
  logic [72:0] prev_beat = '0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] word(input int pid, input int i);
    return {16'hC0DE, pid[15:0], i[31:0]};
  endfunction

  // FIFO models (normal mode, one-cycle read latency) and tready driver
  always @(posedge clk) begin
    if (rden_wcf) begin
      chk("rden_wcf_while_empty", rdempty_wcf, 1'b0);
      if (wcf_q.size() != 0) dataout_wcf <= wcf_q.pop_front();
    end
    if (rden_wf) begin
      chk("rden_wf_while_empty", rdempty_wf, 1'b0);
      if (wf_q.size() != 0) dataout_wf <= wf_q.pop_front();
      wf_pops++;
    end
    if (m_axis_tvalid && m_axis_tready) beats_acc++;
    #1;
    rdempty_wcf   = (wcf_q.size() == 0);
    rdempty_wf    = (wf_q.size() == 0);
    m_axis_tready = ($urandom_range(99) < ready_pct);
  end

  // Monitor: pops the scoreboard on every accepted beat, checks hold while stalled
  always @(negedge clk) begin
    if (!reset_) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        chk("hold_while_stalled", {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast},
            {1'b1, prev_beat});
      if (m_axis_tvalid && m_axis_tready) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=%0h expected=none",
                   {m_axis_tdata, m_axis_tkeep, m_axis_tlast});
        end else begin
          chk("beat", {m_axis_tdata, m_axis_tkeep, m_axis_tlast}, sb_q.pop_front());
        end
      end
      if (err_zero_len) zl_cnt++;
      if (err_len) el_cnt++;
      if (wf_pops - beats_acc > max_out) max_out = wf_pops - beats_acc;
      stall_prev = m_axis_tvalid && !m_axis_tready;
      prev_beat  = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
    end
  end

  task automatic wait_done(input string nm, input int max_cyc);
    int n;
    n = 0;
    while ((wcf_q.size() != 0 || sb_q.size() != 0 || busy) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (n >= max_cyc) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=%0d_cycles required=done_within_%0d", nm, n, max_cyc);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic run_pkt(input int cnt, input int nb, input logic [7:0] lk,
                         input int pid, input int pct, input int exp_el);
    int p0, z0, e0;
    ready_pct = pct;
    p0 = wf_pops;
    z0 = zl_cnt;
    e0 = el_cnt;
    for (int i = 0; i < nb; i++) begin
      wf_q.push_back(word(pid, i));
      sb_q.push_back({word(pid, i), (i == nb - 1) ? lk : 8'hFF, (i == nb - 1)});
    end
    wcf_q.push_back({16'hBEEF, cnt[15:0]});
    wait_done($sformatf("pkt%0d", pid), nb * 20 + 100);
    chk($sformatf("pkt%0d_rden_wf_pulses", pid), wf_pops - p0, nb);
    chk($sformatf("pkt%0d_err_len_pulses", pid), el_cnt - e0, exp_el);
    chk($sformatf("pkt%0d_err_zero_len_pulses", pid), zl_cnt - z0, 0);
    chk($sformatf("pkt%0d_busy_after", pid), busy, 1'b0);
  endtask

  initial begin
    int p0, z0, e0, b0, n;

    repeat (3) @(negedge clk);
    chk("reset_outputs", {rden_wcf, rden_wf, m_axis_tvalid, m_axis_tlast, err_zero_len,
                          err_len, busy, m_axis_tdata, m_axis_tkeep}, '0);
    reset_ = 1'b1;
    repeat (2) @(negedge clk);

    // count, beats, last keep, id, ready %, err_len pulses
    run_pkt(64,   8,    8'hFF, 1, 100, 0);
    run_pkt(61,   8,    8'h1F, 2, 100, 0);
    run_pkt(1,    1,    8'h01, 3, 100, 0);
    max_out = 0;
    run_pkt(128,  16,   8'hFF, 4, 30,  0);
    chk("outstanding_over_2", (max_out > 2), 1'b0);

    // Zero count followed by an 8-byte packet
    ready_pct = 100;
    p0 = wf_pops;
    z0 = zl_cnt;
    wf_q.push_back(word(5, 0));
    sb_q.push_back({word(5, 0), 8'hFF, 1'b1});
    wcf_q.push_back(32'h0000_0000);
    wcf_q.push_back(32'h0000_0008);
    wait_done("zero_then_8", 200);
    chk("zero_len_pulses", zl_cnt - z0, 1);
    chk("zero_then_8_rden_wf_pulses", wf_pops - p0, 1);

    run_pkt(9601, 1201, 8'h01, 6, 100, 1);

    // Underrun mid-packet: only 3 of 8 words available
    p0 = wf_pops;
    z0 = zl_cnt;
    e0 = el_cnt;
    b0 = beats_acc;
    for (int i = 0; i < 3; i++) begin
      wf_q.push_back(word(7, i));
      sb_q.push_back({word(7, i), 8'hFF, 1'b0});
    end
    wcf_q.push_back(32'h0000_0040);
    n = 0;
    while (beats_acc - b0 < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    chk("underrun_beats", beats_acc - b0, 3);
    chk("underrun_tvalid", m_axis_tvalid, 1'b0);
    chk("underrun_busy", busy, 1'b1);
    chk("underrun_rden_wf_pulses", wf_pops - p0, 3);
    chk("underrun_no_error", {zl_cnt - z0, el_cnt - e0}, 0);

    // Reset during DATA
    reset_ = 1'b0;
    wcf_q.delete();
    wf_q.delete();
    sb_q.delete();
    #1;
    chk("midpkt_reset_outputs", {rden_wcf, rden_wf, m_axis_tvalid, m_axis_tlast, err_zero_len,
                                 err_len, busy, m_axis_tdata, m_axis_tkeep}, '0);
    repeat (3) @(negedge clk);
    reset_ = 1'b1;
    repeat (2) @(negedge clk);

    run_pkt(8, 1, 8'hFF, 8, 100, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=still_running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
